// File: rtl/ctrl_pkg.sv
// Shared set-state encoding and blank-mask bit positions for the clock
// time-setting controller and the digit mux.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SEC  = 2'd1,
    ST_MIN  = 2'd2,
    ST_HOUR = 2'd3
  } st_e;

  localparam int BLK_SEC  = 0;
  localparam int BLK_MIN  = 1;
  localparam int BLK_HOUR = 2;

  // MODE walks RUN -> HOUR -> MIN -> SEC -> RUN, i.e. a down-count mod 4.
  function automatic st_e next_mode(st_e s);
    return st_e'(s - 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, saturating-count debouncer
// and a one-cycle registered press strobe on the debounced rising edge.
module btn_debounce #(
  parameter int DB_W = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  logic            sync1_q, sync2_q;
  logic            lvl_q, lvl_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == {DB_W{1'b1}}) lvl_d = sync2_q;
      else                       cnt_d = cnt_q + 1'b1;
    end
    press_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = lvl_q;
  assign o_press = press_q;

endmodule

// File: rtl/set_ctrl.sv
// Time-setting controller: MODE/INC buttons drive the RUN/HOUR/MIN/SEC set
// FSM, auto-repeat, idle timeout and the edited-field blink mask.
module set_ctrl
  import ctrl_pkg::*;
#(
  parameter int DB_W          = 10,
  parameter int HOLD_TICKS    = 8,
  parameter int REPEAT_TICKS  = 2,
  parameter int TIMEOUT_TICKS = 64,
  parameter int BLINK_FRAMES  = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_latch,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  output logic [1:0] o_target,
  output logic       o_inc_hr,
  output logic       o_inc_min,
  output logic       o_clr_sec,
  output logic       o_run,
  output logic [2:0] o_blank
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic mode_press, inc_press, inc_lvl, mode_lvl_unused;

  btn_debounce #(.DB_W(DB_W)) u_db_mode (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_btn_mode),
    .o_level (mode_lvl_unused),
    .o_press (mode_press)
  );

  btn_debounce #(.DB_W(DB_W)) u_db_inc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_btn_inc),
    .o_level (inc_lvl),
    .o_press (inc_press)
  );

  st_e          tgt_q, tgt_d;
  logic         inc_hr_q, inc_hr_d, inc_min_q, inc_min_d, clr_sec_q, clr_sec_d;
  logic         run_q, run_d, phase_q, phase_d;
  logic [2:0]   blank_q, blank_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [FW-1:0] frame_q, frame_d;
  logic         fire, rpt_state;

  always_comb begin
    tgt_d     = tgt_q;
    inc_hr_d  = 1'b0;
    inc_min_d = 1'b0;
    clr_sec_d = 1'b0;
    hold_d    = hold_q;
    rpt_d     = rpt_q;
    idle_d    = idle_q;
    frame_d   = frame_q;
    phase_d   = phase_q;
    fire      = 1'b0;
    blank_d   = 3'b000;

    // MODE beats INC when both land in the same cycle.
    if (mode_press) begin
      tgt_d = next_mode(tgt_q);
    end else if (inc_press) begin
      case (tgt_q)
        ST_HOUR: inc_hr_d  = 1'b1;
        ST_MIN:  inc_min_d = 1'b1;
        ST_SEC:  clr_sec_d = 1'b1;
        default: ;
      endcase
    end

    // A press on the expiring tick wins, so presses are checked first.
    if (tgt_q == ST_RUN || mode_press || inc_press) begin
      idle_d = '0;
    end else if (i_tick) begin
      if (idle_q == IW'(TIMEOUT_TICKS - 1)) begin
        idle_d = '0;
        tgt_d  = ST_RUN;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    rpt_state = (tgt_q == ST_HOUR) || (tgt_q == ST_MIN);
    if (!inc_lvl || mode_press || !rpt_state || tgt_d != tgt_q) begin
      hold_d = '0;
      rpt_d  = '0;
    end else if (i_tick) begin
      if (hold_q != HW'(HOLD_TICKS)) begin
        hold_d = hold_q + 1'b1;
        fire   = (hold_q == HW'(HOLD_TICKS - 1));
      end else if (rpt_q == RW'(REPEAT_TICKS - 1)) begin
        rpt_d = '0;
        fire  = 1'b1;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
    if (fire) begin
      if (tgt_q == ST_HOUR) inc_hr_d  = 1'b1;
      else                  inc_min_d = 1'b1;
    end

    if (i_latch) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    // Keep the field being edited visible right after it changes.
    if (inc_hr_d || inc_min_d || clr_sec_d) begin
      frame_d = '0;
      phase_d = 1'b0;
    end
    if (tgt_d == ST_RUN) phase_d = 1'b0;

    if (phase_d) begin
      case (tgt_d)
        ST_SEC:  blank_d[BLK_SEC]  = 1'b1;
        ST_MIN:  blank_d[BLK_MIN]  = 1'b1;
        ST_HOUR: blank_d[BLK_HOUR] = 1'b1;
        default: ;
      endcase
    end

    run_d = (tgt_d != ST_SEC);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tgt_q     <= ST_RUN;
      inc_hr_q  <= 1'b0;
      inc_min_q <= 1'b0;
      clr_sec_q <= 1'b0;
      run_q     <= 1'b1;
      blank_q   <= 3'b000;
      phase_q   <= 1'b0;
      hold_q    <= '0;
      rpt_q     <= '0;
      idle_q    <= '0;
      frame_q   <= '0;
    end else begin
      tgt_q     <= tgt_d;
      inc_hr_q  <= inc_hr_d;
      inc_min_q <= inc_min_d;
      clr_sec_q <= clr_sec_d;
      run_q     <= run_d;
      blank_q   <= blank_d;
      phase_q   <= phase_d;
      hold_q    <= hold_d;
      rpt_q     <= rpt_d;
      idle_q    <= idle_d;
      frame_q   <= frame_d;
    end
  end

  assign o_target  = tgt_q;
  assign o_inc_hr  = inc_hr_q;
  assign o_inc_min = inc_min_q;
  assign o_clr_sec = clr_sec_q;
  assign o_run     = run_q;
  assign o_blank   = blank_q;

endmodule

// File: tb/tb_set_ctrl.sv
// Directed bench for set_ctrl with DB_W=3 (press lands 10 cycles after a
// stable raw level, FSM outputs one cycle later).
module tb_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, latch = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [1:0] target;
  logic       inc_hr, inc_min, clr_sec, run;
  logic [2:0] blank;

  int checks = 0, fails = 0;
  int n_hr = 0, n_min = 0, n_clr = 0, bad = 0;
  logic p_hr = 1'b0, p_min = 1'b0, p_clr = 1'b0;
  int s_hr, s_min, s_clr;

  set_ctrl #(.DB_W(3)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tick     (tick),
    .i_latch    (latch),
    .i_btn_mode (btn_mode),
    .i_btn_inc  (btn_inc),
    .o_target   (target),
    .o_inc_hr   (inc_hr),
    .o_inc_min  (inc_min),
    .o_clr_sec  (clr_sec),
    .o_run      (run),
    .o_blank    (blank)
  );

  always #5 clk = ~clk;

  // Pulse counters plus shape errors (overlap or longer than one cycle).
  always @(negedge clk) begin
    n_hr  += int'(inc_hr);
    n_min += int'(inc_min);
    n_clr += int'(clr_sec);
    if (int'(inc_hr) + int'(inc_min) + int'(clr_sec) > 1) bad++;
    if ((inc_hr && p_hr) || (inc_min && p_min) || (clr_sec && p_clr)) bad++;
    p_hr  = inc_hr;
    p_min = inc_min;
    p_clr = clr_sec;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic do_latch(input int n);
    repeat (n) begin
      latch = 1'b1; step();
      latch = 1'b0; step();
    end
  endtask

  task automatic snap();
    s_hr = n_hr; s_min = n_min; s_clr = n_clr;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step(11);
    btn_mode = 1'b0; step(12);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; step(11);
    btn_inc = 1'b0; step(12);
  endtask

  initial begin
    step(2);
    chk("rst_target", int'(target), 0);
    chk("rst_run", int'(run), 1);
    chk("rst_blank", int'(blank), 0);
    chk("rst_pulses", int'({inc_hr, inc_min, clr_sec}), 0);
    rst_n = 1'b1;
    step(2);

    // Bounce: five toggles, last edge rising, then held.
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
    btn_mode = 1'b1;
    step(10);
    chk("bounce_early", int'(target), 0);
    step();
    chk("bounce_press", int'(target), 3);
    step(8);
    btn_mode = 1'b0; step(12);
    chk("bounce_single", int'(target), 3);

    // Back to RUN, then the set sequence.
    press_mode(); press_mode(); press_mode();
    chk("wrap_run", int'(target), 0);
    press_mode(); chk("seq_hour", int'(target), 3);
    press_mode(); chk("seq_min", int'(target), 2);
    press_mode(); chk("seq_sec", int'(target), 1);
    chk("seq_run_off", int'(run), 0);
    snap();
    press_inc();
    chk("seq_clr_sec", n_clr - s_clr, 1);
    chk("seq_no_inc", (n_hr - s_hr) + (n_min - s_min), 0);
    press_mode();
    chk("seq_back_run", int'(target), 0);
    chk("seq_run_on", int'(run), 1);

    // INC in RUN is ignored.
    snap();
    press_inc();
    chk("run_inc_ignored", (n_hr - s_hr) + (n_min - s_min) + (n_clr - s_clr), 0);

    // Auto-repeat in MIN: 1 press + repeats at ticks 8,10,12,14.
    press_mode(); press_mode();
    chk("rpt_in_min", int'(target), 2);
    snap();
    btn_inc = 1'b1; step(11);
    do_tick(14);
    chk("rpt_count", n_min - s_min, 5);
    btn_inc = 1'b0; step(12);
    do_tick(4);
    chk("rpt_release", n_min - s_min, 5);
    chk("rpt_no_hr", n_hr - s_hr, 0);

    // Timeout with a coincident INC press on the expiring tick.
    press_mode(); press_mode(); press_mode();
    chk("to_in_hour", int'(target), 3);
    do_tick(63);
    chk("to_63_stays", int'(target), 3);
    snap();
    btn_inc = 1'b1; step(10);
    tick = 1'b1; step();
    tick = 1'b0;
    chk("to_collide_state", int'(target), 3);
    step();
    chk("to_collide_pulse", n_hr - s_hr, 1);
    btn_inc = 1'b0; step(12);
    do_tick(63);
    chk("to_63_again", int'(target), 3);
    do_tick(1);
    chk("to_expire", int'(target), 0);

    // Blink in MIN.
    press_mode(); press_mode();
    do_latch(31);
    chk("blink_31", int'(blank), 0);
    do_latch(1);
    chk("blink_32", int'(blank), 2);
    snap();
    btn_inc = 1'b1; step(10);
    chk("blink_before_inc", int'(blank), 2);
    step();
    chk("blink_inc_clear", int'(blank), 0);
    btn_inc = 1'b0; step(12);
    chk("blink_inc_pulse", n_min - s_min, 1);

    // MODE and INC together: MODE wins.
    snap();
    btn_mode = 1'b1; btn_inc = 1'b1; step(11);
    btn_mode = 1'b0; btn_inc = 1'b0; step(12);
    chk("both_target", int'(target), 1);
    chk("both_no_inc", (n_min - s_min) + (n_clr - s_clr), 0);

    // Reset while INC is held and repeating in HOUR.
    press_mode(); press_mode();
    chk("rr_in_hour", int'(target), 3);
    btn_inc = 1'b1; step(11);
    do_tick(10);
    rst_n = 1'b0; #1;
    chk("rr_target", int'(target), 0);
    chk("rr_run", int'(run), 1);
    chk("rr_blank", int'(blank), 0);
    chk("rr_pulses", int'({inc_hr, inc_min, clr_sec}), 0);
    snap();
    step();
    rst_n = 1'b1;
    do_tick(12);
    chk("rr_no_pulse", (n_hr - s_hr) + (n_min - s_min) + (n_clr - s_clr), 0);
    chk("rr_still_run", int'(target), 0);
    btn_inc = 1'b0; step(12);

    chk("pulse_shape", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
